fir_result_pool: RTL and testbench

Output stage directly downstream of the multi-channel FIR core. It consumes that core's 32-bit result stream, which has no backpressure. Each result goes through bias add, rounding right-shift, optional ReLU and saturation to OUT_WIDTH. Optional 2x2 max pooling follows, and results are buffered in an output FIFO with a valid/ready handshake toward the writeback or next-layer loader.

---
 rtl/fir_result_pool.sv | 218 +++++++++++++++++++++
 tb/tb_fir_result_pool.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_pool.sv
// Post-FIR output stage: bias, rounding shift, ReLU, saturation, optional 2x2 max-pool, output FIFO.
// 5 cycles from result_vld_i to pool_vld_o; input never stalls, so a sample that meets a full FIFO is dropped and flagged.
module fir_result_pool #(
    parameter int RES_COL    = 14,
    parameter int RES_ROW    = 14,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          result_i,
    input  logic                 result_vld_i,
    input  logic                 result_finish_i,
    input  logic [15:0]          bias_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    input  logic                 pool_en_i,
    output logic [OUT_WIDTH-1:0] pool_o,
    output logic                 pool_vld_o,
    input  logic                 pool_rdy_i,
    output logic                 frame_done_o,
    output logic                 overflow_o
);
    localparam int NPIX = RES_COL * RES_ROW;
    localparam int ICW  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (RES_COL > 1) ? $clog2(RES_COL) : 1;
    localparam int RW   = (RES_ROW > 1) ? $clog2(RES_ROW) : 1;
    localparam int LB   = (RES_COL / 2 > 0) ? RES_COL / 2 : 1;
    localparam int LW   = (LB > 1) ? $clog2(LB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [ICW-1:0] IN_LAST  = ICW'(NPIX - 1);
    localparam logic [CW-1:0]  COL_LAST = CW'(RES_COL - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(RES_ROW - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef logic signed [OUT_WIDTH-1:0] samp_t;

    localparam logic signed [33:0] SAT_MAX = (34'sd1 <<< (OUT_WIDTH - 1)) - 34'sd1;
    localparam logic signed [33:0] SAT_MIN = -(34'sd1 <<< (OUT_WIDTH - 1));
    localparam samp_t SAT_HI = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam samp_t SAT_LO = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    // input-side frame tracking and frame-start config
    logic [ICW-1:0]     in_cnt_q, in_cnt_d;
    logic [15:0]        bias_q, bias_d;
    logic [4:0]         shift_q, shift_d;
    logic               relu_q, relu_d, pool_q, pool_d;
    logic               frame_start, in_last, short_end;

    logic               s1_vld_q, s1_vld_d, s1_eof_q, s1_eof_d;
    logic signed [33:0] s1_sum_q, s1_sum_d;
    logic [4:0]         s1_shift_q, s1_shift_d;
    logic               s1_relu_q, s1_relu_d, s1_pool_q, s1_pool_d;

    logic               s2_vld_q, s2_vld_d, s2_eof_q, s2_eof_d;
    logic signed [33:0] s2_val_q, s2_val_d, rnd, sat_v;
    logic               s2_relu_q, s2_relu_d, s2_pool_q, s2_pool_d;

    logic               s3_vld_q, s3_vld_d, s3_eof_q, s3_eof_d, s3_pool_q, s3_pool_d;
    samp_t              s3_dat_q, s3_dat_d;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    samp_t              pair_q, pair_d, pm;
    samp_t              lb_q [LB], lb_d [LB];
    logic [LW-1:0]      lb_idx;

    logic               s4_vld_q, s4_vld_d, s4_eof_q, s4_eof_d;
    samp_t              s4_dat_q, s4_dat_d;

    samp_t              mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] tag_q, tag_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               push, pop, drop;
    logic               overflow_q, overflow_d, done_q, done_d;

    always_comb begin
        frame_start = result_vld_i && (in_cnt_q == '0);
        in_last     = result_vld_i && (in_cnt_q == IN_LAST);
        short_end   = result_finish_i && !in_last && ((in_cnt_q != '0) || result_vld_i);

        bias_d  = bias_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        pool_d  = pool_q;
        if (frame_start) begin
            bias_d  = bias_i;
            shift_d = shift_i;
            relu_d  = relu_en_i;
            pool_d  = pool_en_i;
        end
        in_cnt_d = in_cnt_q;
        if (in_last || short_end)
            in_cnt_d = '0;
        else if (result_vld_i)
            in_cnt_d = in_cnt_q + 1'b1;

        // Config rides with each sample so a back-to-back frame cannot retune in-flight data.
        s1_vld_d   = result_vld_i;
        s1_eof_d   = in_last || short_end;
        s1_sum_d   = {{2{result_i[31]}}, result_i} + {{18{bias_d[15]}}, bias_d};
        s1_shift_d = shift_d;
        s1_relu_d  = relu_d;
        s1_pool_d  = pool_d;

        rnd = '0;
        if (s1_shift_q != '0)
            rnd[s1_shift_q - 5'd1] = 1'b1;
        s2_val_d  = (s1_sum_q + rnd) >>> s1_shift_q;
        s2_vld_d  = s1_vld_q;
        s2_eof_d  = s1_eof_q;
        s2_relu_d = s1_relu_q;
        s2_pool_d = s1_pool_q;

        sat_v = (s2_relu_q && s2_val_q[33]) ? '0 : s2_val_q;
        if (sat_v > SAT_MAX)
            s3_dat_d = SAT_HI;
        else if (sat_v < SAT_MIN)
            s3_dat_d = SAT_LO;
        else
            s3_dat_d = sat_v[OUT_WIDTH-1:0];
        s3_vld_d  = s2_vld_q;
        s3_eof_d  = s2_eof_q;
        s3_pool_d = s2_pool_q;

        col_d    = col_q;
        row_d    = row_q;
        pair_d   = pair_q;
        lb_d     = lb_q;
        s4_vld_d = 1'b0;
        s4_eof_d = s3_eof_q;
        s4_dat_d = s4_dat_q;
        lb_idx   = LW'(col_q >> 1);
        pm       = (s3_dat_q > pair_q) ? s3_dat_q : pair_q;
        if (s3_vld_q) begin
            if (!s3_pool_q) begin
                s4_vld_d = 1'b1;
                s4_dat_d = s3_dat_q;
            end else if (!col_q[0]) begin
                pair_d = s3_dat_q;
            end else if (!row_q[0]) begin
                lb_d[lb_idx] = pm;
            end else begin
                s4_vld_d = 1'b1;
                s4_dat_d = (pm > lb_q[lb_idx]) ? pm : lb_q[lb_idx];
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // Trailing odd column/row never completes a window, so restarting the counters is enough.
        if (s3_eof_q) begin
            col_d = '0;
            row_d = '0;
        end

        pop      = (cnt_q != '0) && pool_rdy_i;
        push     = s4_vld_q && ((cnt_q != FULL_CNT) || pop);
        drop     = s4_vld_q && (cnt_q == FULL_CNT) && !pop;
        mem_d    = mem_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (pop) begin
            tag_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        // End of frame marks the newest entry; when nothing is left, done fires straight away.
        if (push) begin
            mem_d[wr_ptr_q] = s4_dat_q;
            tag_d[wr_ptr_q] = s4_eof_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else if (s4_eof_q && (cnt_d != '0)) begin
            tag_d[wr_ptr_q - 1'b1] = 1'b1;
        end
        done_d     = (pop && tag_q[rd_ptr_q]) || (s4_eof_q && !push && (cnt_d == '0));
        overflow_d = (frame_start ? 1'b0 : overflow_q) | drop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_cnt_q <= '0; bias_q <= '0; shift_q <= '0; relu_q <= 1'b0; pool_q <= 1'b0;
            s1_vld_q <= 1'b0; s1_eof_q <= 1'b0; s1_sum_q <= '0;
            s1_shift_q <= '0; s1_relu_q <= 1'b0; s1_pool_q <= 1'b0;
            s2_vld_q <= 1'b0; s2_eof_q <= 1'b0; s2_val_q <= '0; s2_relu_q <= 1'b0; s2_pool_q <= 1'b0;
            s3_vld_q <= 1'b0; s3_eof_q <= 1'b0; s3_dat_q <= '0; s3_pool_q <= 1'b0;
            col_q <= '0; row_q <= '0; pair_q <= '0; lb_q <= '{default: '0};
            s4_vld_q <= 1'b0; s4_eof_q <= 1'b0; s4_dat_q <= '0;
            mem_q <= '{default: '0}; tag_q <= '0;
            wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
            overflow_q <= 1'b0; done_q <= 1'b0;
        end else begin
            in_cnt_q <= in_cnt_d; bias_q <= bias_d; shift_q <= shift_d; relu_q <= relu_d; pool_q <= pool_d;
            s1_vld_q <= s1_vld_d; s1_eof_q <= s1_eof_d; s1_sum_q <= s1_sum_d;
            s1_shift_q <= s1_shift_d; s1_relu_q <= s1_relu_d; s1_pool_q <= s1_pool_d;
            s2_vld_q <= s2_vld_d; s2_eof_q <= s2_eof_d; s2_val_q <= s2_val_d;
            s2_relu_q <= s2_relu_d; s2_pool_q <= s2_pool_d;
            s3_vld_q <= s3_vld_d; s3_eof_q <= s3_eof_d; s3_dat_q <= s3_dat_d; s3_pool_q <= s3_pool_d;
            col_q <= col_d; row_q <= row_d; pair_q <= pair_d; lb_q <= lb_d;
            s4_vld_q <= s4_vld_d; s4_eof_q <= s4_eof_d; s4_dat_q <= s4_dat_d;
            mem_q <= mem_d; tag_q <= tag_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; cnt_q <= cnt_d;
            overflow_q <= overflow_d; done_q <= done_d;
        end
    end

    assign pool_vld_o   = (cnt_q != '0);
    assign pool_o       = pool_vld_o ? mem_q[rd_ptr_q] : '0;
    assign frame_done_o = done_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fir_result_pool.sv
// Directed bench for fir_result_pool on a 4x4 result frame: single-sample vector table plus
// hand-written latency, pooling, overflow, reset and short-frame sequences.
module tb_fir_result_pool;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] result_i = '0;
    logic        result_vld_i = 1'b0;
    logic        result_finish_i = 1'b0;
    logic [15:0] bias_i = '0;
    logic [4:0]  shift_i = '0;
    logic        relu_en_i = 1'b0;
    logic        pool_en_i = 1'b0;
    logic [7:0]  pool_o;
    logic        pool_vld_o;
    logic        pool_rdy_i = 1'b0;
    logic        frame_done_o;
    logic        overflow_o;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    fir_result_pool #(
        .RES_COL(4), .RES_ROW(4), .OUT_WIDTH(8), .FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .result_i(result_i), .result_vld_i(result_vld_i), .result_finish_i(result_finish_i),
        .bias_i(bias_i), .shift_i(shift_i), .relu_en_i(relu_en_i), .pool_en_i(pool_en_i),
        .pool_o(pool_o), .pool_vld_o(pool_vld_o), .pool_rdy_i(pool_rdy_i),
        .frame_done_o(frame_done_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done_o) done_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] bias;
        logic [4:0]  shift;
        logic        relu;
        logic [31:0] din;
        int          exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        result_i     = d;
        result_vld_i = 1'b1;
        tick();
        result_vld_i = 1'b0;
    endtask

    task automatic finish_pulse();
        result_finish_i = 1'b1;
        tick();
        result_finish_i = 1'b0;
    endtask

    task automatic pop_expect(input string name, input int exp);
        int w = 0;
        while (!pool_vld_o && w < 40) begin
            tick();
            w++;
        end
        if (!pool_vld_o) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: pool_vld_o stayed low for 40 cycles, expected sample %0d", name, exp);
        end else begin
            check(name, $signed(pool_o), exp);
            pool_rdy_i = 1'b1;
            tick();
            pool_rdy_i = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int w = 0;
        while (!frame_done_o && w < 40) begin
            tick();
            w++;
        end
        n_vec++;
        if (!frame_done_o) begin
            n_err++;
            $display("FAIL %s: frame_done_o stayed 0 for 40 cycles, expected 1", name);
        end
    endtask

    initial begin
        int lat;
        int d0;

        vec[0]  = '{16'd0,      5'd0,  1'b0, 32'd100,        100};
        vec[1]  = '{16'd0,      5'd0,  1'b0, -32'sd300,      -128};
        vec[2]  = '{16'd0,      5'd0,  1'b0, 32'd127,        127};
        vec[3]  = '{16'd0,      5'd0,  1'b0, 32'd128,        127};
        vec[4]  = '{16'd0,      5'd0,  1'b0, -32'sd129,      -128};
        vec[5]  = '{16'd0,      5'd2,  1'b0, 32'd5,          1};
        vec[6]  = '{16'd0,      5'd2,  1'b0, 32'd6,          2};
        vec[7]  = '{16'd0,      5'd2,  1'b0, -32'sd6,        -1};
        vec[8]  = '{16'd0,      5'd2,  1'b0, -32'sd4,        -1};
        vec[9]  = '{16'd3,      5'd2,  1'b0, 32'd1,          1};
        vec[10] = '{-16'sd10,   5'd0,  1'b1, 32'd5,          0};
        vec[11] = '{-16'sd10,   5'd0,  1'b1, 32'd200,        127};
        vec[12] = '{16'd0,      5'd31, 1'b0, 32'h7fffffff,   1};
        vec[13] = '{16'h7fff,   5'd0,  1'b0, 32'h7fffffff,   127};
        vec[14] = '{16'd0,      5'd4,  1'b0, -32'sd9,        -1};
        vec[15] = '{16'd0,      5'd1,  1'b0, -32'sd3,        -1};
        vec[16] = '{16'd0,      5'd0,  1'b1, -32'sd1000,     0};
        vec[17] = '{16'h8000,   5'd0,  1'b0, 32'h80000000,   -128};
        vec[18] = '{16'd0,      5'd3,  1'b0, 32'd12,         2};

        #2 reset = 1'b1;
        repeat (3) tick();
        check("rst_vld", pool_vld_o, 0);
        check("rst_dat", pool_o, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_ovf", overflow_o, 0);
        reset = 1'b0;
        tick();

        // latency and saturation on a two-sample stream
        send(32'd100);
        send(-32'sd300);
        lat = 2;
        while (!pool_vld_o && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, 5);
        pop_expect("lat_s0", 100);
        pop_expect("lat_s1", -128);
        finish_pulse();
        wait_done("lat_done");

        for (int i = 0; i < NV; i++) begin
            bias_i    = vec[i].bias;
            shift_i   = vec[i].shift;
            relu_en_i = vec[i].relu;
            pool_en_i = 1'b0;
            send(vec[i].din);
            finish_pulse();
            pop_expect($sformatf("vec%0d", i), vec[i].exp);
            wait_done($sformatf("vec%0d_done", i));
        end

        // 2x2 pooling over a full 4x4 frame; the trailing finish is after completion
        bias_i = '0; shift_i = '0; relu_en_i = 1'b0; pool_en_i = 1'b1;
        repeat (3) tick();
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) send(32'(i));
        finish_pulse();
        pop_expect("pool0", 5);
        pop_expect("pool1", 7);
        pop_expect("pool2", 13);
        check("pool_no_early_done", done_cnt - d0, 0);
        pop_expect("pool3", 15);
        repeat (4) tick();
        check("pool_done_once", done_cnt - d0, 1);
        check("pool_only4", pool_vld_o, 0);

        // overflow with the consumer stalled
        pool_en_i = 1'b0;
        for (int i = 1; i <= 17; i++) send(32'(i));
        finish_pulse();
        repeat (10) tick();
        check("ovf_set", overflow_o, 1);
        check("ovf_full_vld", pool_vld_o, 1);
        for (int i = 1; i <= 16; i++) pop_expect($sformatf("ovf_pop%0d", i), i);
        repeat (8) tick();
        check("ovf_drained", pool_vld_o, 0);
        check("ovf_sticky", overflow_o, 1);
        send(32'd50);
        check("ovf_clear", overflow_o, 0);
        send(32'd51);
        repeat (6) tick();
        check("rst_pre_vld", pool_vld_o, 1);

        // asynchronous reset in the middle of a frame
        reset = 1'b1;
        #1;
        check("rst_mid_vld", pool_vld_o, 0);
        check("rst_mid_dat", pool_o, 0);
        check("rst_mid_done", frame_done_o, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // short pooled frame of 6 samples, then a full frame must start at position 0
        pool_en_i = 1'b1;
        for (int i = 0; i < 6; i++) send(32'(i));
        finish_pulse();
        pop_expect("short_pool", 5);
        wait_done("short_done");
        repeat (4) tick();
        check("short_only1", pool_vld_o, 0);
        for (int i = 0; i < 16; i++) send(32'(-i));
        pop_expect("after_short0", 0);
        pop_expect("after_short1", -2);
        pop_expect("after_short2", -8);
        pop_expect("after_short3", -10);
        wait_done("after_short_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
